ysyx_23060208_rd_arbiter: RTL and testbench

YSYX_23060208_RD_ARBITER -- requirements
Module: ysyx_23060208_rd_arbiter

---
 rtl/ysyx_23060208_rd_arbiter.sv | 146 ++++++++++++++
 tb/tb_ysyx_23060208_rd_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060208_rd_arbiter.sv
// Two-master read arbiter: round-robin grant of IFU (m0) / EXU (m1) onto one
// downstream AXI read port, one outstanding burst, R channel passed straight through.
module ysyx_23060208_rd_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    m0_arvalid,
  output logic                    m0_arready,
  input  logic [DATA_WIDTH-1:0]   m0_araddr,
  input  logic [7:0]              m0_arlen,
  input  logic [2:0]              m0_arsize,
  output logic                    m0_rvalid,
  input  logic                    m0_rready,
  output logic [2*DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]              m0_rresp,
  output logic                    m0_rlast,
  input  logic                    m1_arvalid,
  output logic                    m1_arready,
  input  logic [DATA_WIDTH-1:0]   m1_araddr,
  input  logic [7:0]              m1_arlen,
  input  logic [2:0]              m1_arsize,
  output logic                    m1_rvalid,
  input  logic                    m1_rready,
  output logic [2*DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]              m1_rresp,
  output logic                    m1_rlast,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_araddr,
  output logic [3:0]              s_arid,
  output logic [7:0]              s_arlen,
  output logic [2:0]              s_arsize,
  output logic [1:0]              s_arburst,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  input  logic [2*DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]              s_rresp,
  input  logic                    s_rlast,
  input  logic [3:0]              s_rid
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_grant;
  logic                  r_arvalid;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [7:0]            r_cnt;

  logic       w_grant_go;
  logic       w_pick;
  logic       w_data;
  logic       w_sel0;
  logic       w_sel1;
  logic       w_hs;
  logic       w_last;
  logic [1:0] w_resp;

  // r_grant doubles as the last-granted index, so contention favours the other master.
  assign w_pick     = (m0_arvalid & m1_arvalid) ? ~r_grant : m1_arvalid;
  // Gated by reset so arready stays low while the block is held in reset.
  assign w_grant_go = (r_state == ST_IDLE) & (m0_arvalid | m1_arvalid) & reset;
  assign w_data     = (r_state == ST_DATA);
  assign w_sel0     = w_data & ~r_grant;
  assign w_sel1     = w_data & r_grant;
  assign s_rready   = w_data & (r_grant ? m1_rready : m0_rready);
  assign w_hs       = w_data & s_rvalid & s_rready;
  assign w_last     = s_rlast | (r_cnt == r_len);
  assign w_resp     = (s_rid[0] != r_grant) ? 2'b10 : s_rresp;

  assign m0_arready = w_grant_go & ~w_pick;
  assign m1_arready = w_grant_go & w_pick;

  assign m0_rvalid  = w_sel0 & s_rvalid;
  assign m0_rdata   = w_sel0 ? s_rdata : {(2*DATA_WIDTH){1'b0}};
  assign m0_rresp   = w_sel0 ? w_resp : 2'b00;
  assign m0_rlast   = w_sel0 & w_last;
  assign m1_rvalid  = w_sel1 & s_rvalid;
  assign m1_rdata   = w_sel1 ? s_rdata : {(2*DATA_WIDTH){1'b0}};
  assign m1_rresp   = w_sel1 ? w_resp : 2'b00;
  assign m1_rlast   = w_sel1 & w_last;

  assign s_arvalid  = r_arvalid;
  assign s_araddr   = r_addr;
  assign s_arid     = {3'b000, r_grant};
  assign s_arlen    = r_len;
  assign s_arsize   = r_size;
  assign s_arburst  = 2'b01;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_go) w_next = ST_ADDR;
        else            w_next = ST_IDLE;
      end
      ST_ADDR: begin
        if (r_arvalid & s_arready) w_next = ST_DATA;
        else                       w_next = ST_ADDR;
      end
      ST_DATA: begin
        if (w_hs & w_last) w_next = ST_IDLE;
        else               w_next = ST_DATA;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_grant   <= 1'b0;
      r_arvalid <= 1'b0;
      r_addr    <= {DATA_WIDTH{1'b0}};
      r_len     <= 8'd0;
      r_size    <= 3'd0;
      r_cnt     <= 8'd0;
    end else if (w_grant_go) begin
      r_grant   <= w_pick;
      r_arvalid <= 1'b1;
      r_addr    <= w_pick ? m1_araddr : m0_araddr;
      r_len     <= w_pick ? m1_arlen  : m0_arlen;
      r_size    <= w_pick ? m1_arsize : m0_arsize;
      r_cnt     <= 8'd0;
    end else begin
      if (r_arvalid & s_arready) r_arvalid <= 1'b0;
      if (w_hs)                  r_cnt     <= r_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_rd_arbiter.sv
// Directed bench for the read arbiter: inputs driven on the falling edge,
// outputs checked 1 time unit later, well away from the rising edge.
module tb_ysyx_23060208_rd_arbiter;

  logic        clock;
  logic        reset;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [31:0] m0_araddr;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic [63:0] m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [31:0] m1_araddr;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize;
  logic [63:0] m1_rdata;
  logic [1:0]  m1_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [31:0] s_araddr;
  logic [3:0]  s_arid, s_rid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;
  logic [63:0] s_rdata;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_23060208_rd_arbiter #(.DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_rvalid(m0_rvalid),
    .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_rvalid(m1_rvalid),
    .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Grant master m alone, hold s_arready low for nwait ADDR cycles, then hand off.
  task automatic grant(input logic m, input logic [31:0] addr, input logic [7:0] len, input int nwait);
    if (m) begin m1_arvalid = 1'b1; m1_araddr = addr; m1_arlen = len; m1_arsize = 3'd3; end
    else   begin m0_arvalid = 1'b1; m0_araddr = addr; m0_arlen = len; m0_arsize = 3'd2; end
    #1;
    check("arready_granted", m ? m1_arready : m0_arready, 64'd1);
    check("arready_other",   m ? m0_arready : m1_arready, 64'd0);
    @(negedge clock);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    #1;
    check("s_arid",    s_arid,    {60'd0, 3'b000, m});
    check("s_araddr",  s_araddr,  {32'd0, addr});
    check("s_arlen",   s_arlen,   {56'd0, len});
    check("s_arsize",  s_arsize,  m ? 64'd3 : 64'd2);
    check("s_arburst", s_arburst, 64'd1);
    for (int k = 0; k < nwait; k++) begin
      check("s_arvalid_wait", s_arvalid, 64'd1);
      check("s_rready_addr",  s_rready,  64'd0);
      @(negedge clock);
      #1;
    end
    s_arready = 1'b1;
    check("s_arvalid_hs", s_arvalid, 64'd1);
    @(negedge clock);
    s_arready = 1'b0;
    #1;
    check("s_arvalid_after", s_arvalid, 64'd0);
  endtask

  // One accepted downstream beat routed to master m.
  task automatic beat(input logic m, input logic [63:0] data, input logic last, input logic [3:0] rid,
                      input logic [1:0] resp, input logic exp_last, input logic [1:0] exp_resp);
    s_rvalid = 1'b1; s_rdata = data; s_rlast = last; s_rid = rid; s_rresp = resp;
    m0_rready = ~m; m1_rready = m;
    #1;
    check("rvalid",       m ? m1_rvalid : m0_rvalid, 64'd1);
    check("rvalid_other", m ? m0_rvalid : m1_rvalid, 64'd0);
    check("rdata",        m ? m1_rdata  : m0_rdata,  data);
    check("rlast",        m ? m1_rlast  : m0_rlast,  {63'd0, exp_last});
    check("rresp",        m ? m1_rresp  : m0_rresp,  {62'd0, exp_resp});
    check("s_rready",     s_rready, 64'd1);
    @(negedge clock);
    s_rvalid = 1'b0; s_rlast = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
  endtask

  initial begin
    logic [7:0] nb;
    reset = 1'b0;
    m0_arvalid = 1'b1; m0_araddr = 32'h0; m0_arlen = 8'd0; m0_arsize = 3'd0; m0_rready = 1'b1;
    m1_arvalid = 1'b1; m1_araddr = 32'h0; m1_arlen = 8'd0; m1_arsize = 3'd0; m1_rready = 1'b1;
    s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 64'hFFFF; s_rresp = 2'b00; s_rlast = 1'b1; s_rid = 4'd0;

    // Reset with requests and beats pending: everything but arburst must be 0.
    @(negedge clock); #1;
    check("rst_m0_arready", m0_arready, 64'd0);
    check("rst_m1_arready", m1_arready, 64'd0);
    check("rst_s_arvalid",  s_arvalid,  64'd0);
    check("rst_s_rready",   s_rready,   64'd0);
    check("rst_m0_rvalid",  m0_rvalid,  64'd0);
    check("rst_m0_rdata",   m0_rdata,   64'd0);
    check("rst_s_arid",     s_arid,     64'd0);
    check("rst_s_arburst",  s_arburst,  64'd1);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // m0 single-beat fetch with a 2-cycle arready delay.
    grant(1'b0, 32'h3000_0000, 8'd0, 2);
    beat(1'b0, 64'h1111_2222_3333_4444, 1'b1, 4'd0, 2'b00, 1'b1, 2'b00);
    s_rvalid = 1'b1; #1;
    check("idle_m0_rvalid", m0_rvalid, 64'd0);
    check("idle_s_rready",  s_rready,  64'd0);
    s_rvalid = 1'b0;
    @(negedge clock);

    // Contention twice: m1 first, then m0.
    m0_arvalid = 1'b1; m0_araddr = 32'hA000_0000; m0_arlen = 8'd0;
    m1_arvalid = 1'b1; m1_araddr = 32'hB000_0000; m1_arlen = 8'd0;
    #1;
    check("rr1_m1_arready", m1_arready, 64'd1);
    check("rr1_m0_arready", m0_arready, 64'd0);
    @(negedge clock);
    m1_arvalid = 1'b0; #1;
    check("rr1_s_arid",    s_arid,    64'd1);
    check("rr1_s_araddr",  s_araddr,  64'hB000_0000);
    check("wait_m0_arready", m0_arready, 64'd0);
    s_arready = 1'b1;
    @(negedge clock);
    s_arready = 1'b0;
    check("wait2_m0_arready", m0_arready, 64'd0);
    beat(1'b1, 64'hBBBB, 1'b1, 4'd1, 2'b00, 1'b1, 2'b00);
    m1_arvalid = 1'b1; #1;
    check("rr2_m0_arready", m0_arready, 64'd1);
    check("rr2_m1_arready", m1_arready, 64'd0);
    @(negedge clock);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; #1;
    check("rr2_s_arid",   s_arid,   64'd0);
    check("rr2_s_araddr", s_araddr, 64'hA000_0000);
    s_arready = 1'b1;
    @(negedge clock);
    s_arready = 1'b0;
    beat(1'b0, 64'hAAAA, 1'b1, 4'd0, 2'b00, 1'b1, 2'b00);

    // m1 4-beat burst with m1_rready toggling every cycle.
    grant(1'b1, 32'h8000_0100, 8'd3, 0);
    nb = 8'd0;
    for (int i = 0; i < 8; i++) begin
      s_rvalid = 1'b1; s_rdata = 64'h100 + {56'd0, nb}; s_rlast = (nb == 8'd3); s_rid = 4'd1;
      s_rresp = 2'b00; m1_rready = i[0];
      #1;
      check("burst_rvalid",   m1_rvalid, 64'd1);
      check("burst_s_rready", s_rready,  {63'd0, i[0]});
      check("burst_rdata",    m1_rdata,  64'h100 + {56'd0, nb});
      check("burst_rlast",    m1_rlast,  {63'd0, (nb == 8'd3)});
      if (i[0]) nb = nb + 8'd1;
      @(negedge clock);
    end
    s_rvalid = 1'b1; m1_rready = 1'b1; #1;
    check("burst_done_rvalid", m1_rvalid, 64'd0);
    s_rvalid = 1'b0; m1_rready = 1'b0; s_rlast = 1'b0;
    @(negedge clock);

    // arlen=1 without s_rlast; first beat carries the wrong ID.
    grant(1'b0, 32'h0000_2000, 8'd1, 0);
    beat(1'b0, 64'hC0, 1'b0, 4'd1, 2'b00, 1'b0, 2'b10);
    beat(1'b0, 64'hC1, 1'b0, 4'd0, 2'b01, 1'b1, 2'b01);
    s_rvalid = 1'b1; #1;
    check("len1_done_rvalid", m0_rvalid, 64'd0);
    s_rvalid = 1'b0;
    @(negedge clock);

    // Reset during beat 2 of 4, then a fresh grant.
    grant(1'b1, 32'h4000_0000, 8'd3, 0);
    beat(1'b1, 64'hD0, 1'b0, 4'd1, 2'b00, 1'b0, 2'b00);
    s_rvalid = 1'b1; s_rdata = 64'hD1; s_rid = 4'd1; m1_rready = 1'b1;
    #1;
    check("pre_rst_rvalid", m1_rvalid, 64'd1);
    reset = 1'b0; #1;
    check("mid_rst_m1_rvalid", m1_rvalid, 64'd0);
    check("mid_rst_m1_rdata",  m1_rdata,  64'd0);
    check("mid_rst_s_rready",  s_rready,  64'd0);
    check("mid_rst_s_arid",    s_arid,    64'd0);
    check("mid_rst_s_arlen",   s_arlen,   64'd0);
    check("mid_rst_s_arburst", s_arburst, 64'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock); #1;
    check("post_rst_m1_rvalid", m1_rvalid, 64'd0);
    check("post_rst_s_rready",  s_rready,  64'd0);
    s_rvalid = 1'b0; m1_rready = 1'b0;
    @(negedge clock);
    grant(1'b0, 32'h3000_0040, 8'd0, 1);
    beat(1'b0, 64'hE0, 1'b1, 4'd0, 2'b00, 1'b1, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
